// File: rtl/xdma_write_burst_framer.sv
// Splits one write task into bursts bounded by MAX_BURST_BEATS and 4 KiB pages,
// tagging each beat with its burst address and a last flag.
// Optional: XDMA_WRITE_FRAMER_OUT_REG_EN inserts a two-entry spill register on the output.
module xdma_write_burst_framer #(
  parameter type         data_t          = logic,
  parameter type         addr_t          = logic,
  parameter int unsigned LEN_WIDTH       = 32,
  parameter int unsigned MAX_BURST_BEATS = 256,
  parameter int unsigned BEAT_BYTES      = $bits(data_t) / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  addr_t                task_addr_i,
  input  logic [LEN_WIDTH-1:0] task_len_i,
  input  logic                 task_valid_i,
  output logic                 task_ready_o,
  input  data_t                inp_data_i,
  input  logic                 inp_valid_i,
  output logic                 inp_ready_o,
  output addr_t                oup_addr_o,
  output data_t                oup_data_o,
  output logic                 oup_last_o,
  output logic                 oup_valid_o,
  input  logic                 oup_ready_i,
  output logic                 busy_o
);

  localparam int unsigned AW         = $bits(addr_t);
  localparam int unsigned BEAT_SHIFT = (BEAT_BYTES > 1) ? $clog2(BEAT_BYTES) : 0;
  localparam int unsigned LW1        = LEN_WIDTH + 1;
  // Comparison width must hold both the length and a full page of beats (4096).
  localparam int unsigned CW         = (LW1 > 13) ? LW1 : 13;
  localparam int unsigned AXW        = (AW > 13) ? AW : 13;

  typedef enum logic {IDLE, BURST} state_e;

  state_e               state_q, state_d;
  addr_t                cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic [LW1-1:0]       beat_cnt_q, beat_cnt_d;

  addr_t                task_addr_al;
  logic [11:0]          page_off;
  logic [CW-1:0]        page_room;
  logic [CW-1:0]        len_min;
  logic [LW1-1:0]       burst_len;
  logic [12:0]          byte_step;
  logic [AXW-1:0]       addr_sum;
  addr_t                next_addr;
  logic                 last_beat;
  logic                 in_burst;
  logic                 fr_valid;
  logic                 fr_ready;
  logic                 fire;

  assign task_addr_al = (task_addr_i >> BEAT_SHIFT) << BEAT_SHIFT;

  // Burst length is the tightest of: beats left, burst cap, beats to the page end.
  always_comb begin
    page_off  = 12'(cur_addr_q);
    page_room = CW'((13'd4096 - {1'b0, page_off}) >> BEAT_SHIFT);
    len_min   = CW'(remaining_q);
    if (CW'(MAX_BURST_BEATS) < len_min) len_min = CW'(MAX_BURST_BEATS);
    if (page_room < len_min)            len_min = page_room;
  end

  assign burst_len = LW1'(len_min);
  assign byte_step = 13'(burst_len) << BEAT_SHIFT;
  assign addr_sum  = AXW'(cur_addr_q) + AXW'(byte_step);
  assign next_addr = AW'(addr_sum);
  assign last_beat = (beat_cnt_q == (burst_len - LW1'(1)));

  assign in_burst  = (state_q == BURST);
  assign fr_valid  = in_burst & inp_valid_i;
  assign fire      = fr_valid & fr_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    beat_cnt_d   = beat_cnt_q;
    task_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        task_ready_o = 1'b1;
        // A zero-length task is consumed here without leaving IDLE.
        if (task_valid_i && (task_len_i != '0)) begin
          state_d     = BURST;
          cur_addr_d  = task_addr_al;
          remaining_d = task_len_i;
          beat_cnt_d  = '0;
        end
      end
      BURST: begin
        if (fire) begin
          if (last_beat) begin
            cur_addr_d  = next_addr;
            remaining_d = remaining_q - LEN_WIDTH'(burst_len);
            beat_cnt_d  = '0;
            if (remaining_q == LEN_WIDTH'(burst_len)) state_d = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + LW1'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: non-blocking assignments keep all register updates independent of statement order.
    if (!rst_ni) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

`ifdef XDMA_WRITE_FRAMER_OUT_REG_EN
  // Two-entry spill register: A takes new beats, B catches A when the sink stalls.
  logic  a_full_q, b_full_q;
  addr_t a_addr_q, b_addr_q;
  data_t a_data_q, b_data_q;
  logic  a_last_q, b_last_q;
  logic  a_fill, a_drain, b_fill, b_drain;
  logic  sel_last;

  assign fr_ready = ~a_full_q | ~b_full_q;
  assign a_fill   = fire;
  assign a_drain  = a_full_q & ~b_full_q;
  assign b_fill   = a_drain & ~oup_ready_i;
  assign b_drain  = b_full_q & oup_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: payload registers are reset as well so the outputs read 0 during reset.
    if (!rst_ni) begin
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
      a_addr_q <= '0;
      a_data_q <= '0;
      a_last_q <= 1'b0;
      b_addr_q <= '0;
      b_data_q <= '0;
      b_last_q <= 1'b0;
    end else begin
      a_full_q <= a_fill | (a_full_q & ~a_drain);
      b_full_q <= b_fill | (b_full_q & ~b_drain);
      if (a_fill) begin
        a_addr_q <= cur_addr_q;
        a_data_q <= inp_data_i;
        a_last_q <= last_beat;
      end
      if (b_fill) begin
        b_addr_q <= a_addr_q;
        b_data_q <= a_data_q;
        b_last_q <= a_last_q;
      end
    end
  end

  assign sel_last    = b_full_q ? b_last_q : a_last_q;
  assign oup_valid_o = a_full_q | b_full_q;
  assign oup_addr_o  = b_full_q ? b_addr_q : a_addr_q;
  assign oup_data_o  = b_full_q ? b_data_q : a_data_q;
  assign oup_last_o  = oup_valid_o & sel_last;
  assign inp_ready_o = in_burst & fr_ready;
  assign busy_o      = in_burst | a_full_q | b_full_q;
`else
  assign fr_ready    = oup_ready_i;
  assign oup_valid_o = fr_valid;
  assign oup_addr_o  = cur_addr_q;
  assign oup_data_o  = inp_data_i;
  assign oup_last_o  = in_burst & last_beat;
  assign inp_ready_o = in_burst & oup_ready_i;
  assign busy_o      = in_burst;
`endif

endmodule

// File: tb/tb_xdma_write_burst_framer.sv
// Self-checking bench for xdma_write_burst_framer (64-bit beats, 32-bit addresses, 256-beat cap).
module tb_xdma_write_burst_framer;

  typedef logic [63:0] data_t;
  typedef logic [31:0] addr_t;

  typedef struct {
    addr_t addr;
    data_t data;
    bit    last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  addr_t       task_addr = '0;
  logic [31:0] task_len = '0;
  logic        task_valid = 1'b0;
  logic        task_ready_o;
  data_t       inp_data = '0;
  logic        inp_valid = 1'b0;
  logic        inp_ready_o;
  addr_t       oup_addr_o;
  data_t       oup_data_o;
  logic        oup_last_o;
  logic        oup_valid_o;
  logic        oup_ready = 1'b0;
  logic        busy_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  beat_t       exp_q[$];
  int          model_len[$];
  addr_t       model_addr[$];
  int unsigned data_ctr = 0;
  int          xfers = 0;
  int          lasts = 0;
  addr_t       last_addr = '0;

  always #5 clk = ~clk;

  xdma_write_burst_framer #(
    .data_t          (data_t),
    .addr_t          (addr_t),
    .LEN_WIDTH       (32),
    .MAX_BURST_BEATS (256)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .task_addr_i  (task_addr),
    .task_len_i   (task_len),
    .task_valid_i (task_valid),
    .task_ready_o (task_ready_o),
    .inp_data_i   (inp_data),
    .inp_valid_i  (inp_valid),
    .inp_ready_o  (inp_ready_o),
    .oup_addr_o   (oup_addr_o),
    .oup_data_o   (oup_data_o),
    .oup_last_o   (oup_last_o),
    .oup_valid_o  (oup_valid_o),
    .oup_ready_i  (oup_ready),
    .busy_o       (busy_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic data_t beat_data(input int unsigned idx);
    return {32'hD00D_BEEF, idx};
  endfunction

  // Reference: walk the task in page/cap-sized chunks and list every beat it must produce.
  task automatic build_model(input addr_t addr, input int len);
    addr_t a;
    int    rem;
    int    room;
    int    n;
    int    k;
    a   = addr & ~32'h7;
    rem = len;
    k   = 0;
    model_len.delete();
    model_addr.delete();
    while (rem > 0) begin
      room = (4096 - int'(a % 4096)) / 8;
      n = rem;
      if (n > 256)  n = 256;
      if (n > room) n = room;
      model_len.push_back(n);
      model_addr.push_back(a);
      for (int i = 0; i < n; i++) begin
        exp_q.push_back('{addr: a, data: beat_data(data_ctr + k), last: (i == n - 1)});
        k++;
      end
      a   = a + addr_t'(n * 8);
      rem = rem - n;
    end
  endtask

  // Compare process: every accepted output beat against the model, plus hold-while-stalled.
  initial begin : compare
    bit    prev_stall;
    addr_t prev_addr;
    data_t prev_data;
    logic  prev_last;
    beat_t e;
    prev_stall = 0;
    prev_addr  = '0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        prev_stall = 0;
      end else begin
        if (prev_stall && oup_valid_o) begin
          check("hold_addr", oup_addr_o, prev_addr);
          check("hold_data", oup_data_o, prev_data);
          check("hold_last", oup_last_o, prev_last);
        end
        if (oup_valid_o && oup_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", oup_valid_o, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("beat_addr", oup_addr_o, e.addr);
            check("beat_data", oup_data_o, e.data);
            check("beat_last", oup_last_o, e.last);
            xfers++;
            if (oup_last_o) begin
              lasts++;
              last_addr = oup_addr_o;
            end
          end
        end
        prev_stall = oup_valid_o && !oup_ready;
        prev_addr  = oup_addr_o;
        prev_data  = oup_data_o;
        prev_last  = oup_last_o;
      end
    end
  end

  // Issue one task and stream its beats; abort_after > 0 stops after that many transfers.
  task automatic run_task(input addr_t addr, input int len, input bit stall, input int abort_after);
    logic [31:0] vpat;
    logic [31:0] rpat;
    int          sent;
    int          cyc;
    int          bubbles;
    int          budget;
    bit          fire;
    bit          hold;
    bit          aborted;
    vpat = 32'hB5D3_6E9A;
    rpat = 32'h9C4F_A371;
    build_model(addr, len);
    @(posedge clk); #1;
    task_addr  = addr;
    task_len   = len;
    task_valid = 1'b1;
    inp_valid  = 1'b0;
    @(negedge clk);
    check("task_ready_idle", task_ready_o, 1'b1);
    @(posedge clk); #1;
    task_valid = 1'b0;
    check("busy_after_accept", busy_o, 1'b1);
    check("task_ready_burst", task_ready_o, 1'b0);
    sent    = 0;
    cyc     = 0;
    bubbles = 0;
    hold    = 0;
    aborted = 0;
    budget  = 40 * len + 100;
    while (sent < len && cyc < budget) begin
      if (abort_after > 0 && sent == abort_after) begin
        aborted = 1;
        break;
      end
      inp_data  = beat_data(data_ctr);
      inp_valid = stall ? (hold | vpat[cyc % 32]) : 1'b1;
      oup_ready = stall ? rpat[cyc % 32] : 1'b1;
      @(negedge clk);
      fire = inp_valid && inp_ready_o;
      if (!fire) bubbles++;
      hold = inp_valid && !fire;
      @(posedge clk); #1;
      if (fire) begin
        sent++;
        data_ctr++;
      end
      cyc++;
    end
    if (!aborted) begin
      inp_valid = 1'b0;
      check("beats_sent_in_budget", sent, len);
      check("busy_after_task", busy_o, 1'b0);
      check("model_queue_drained", exp_q.size(), 0);
      if (!stall) check("no_bubbles", bubbles, 0);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    #1 rst_ni = 1'b0;
    #1;
    check("rst_task_ready", task_ready_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_oup_valid", oup_valid_o, 1'b0);
    check("rst_inp_ready", inp_ready_o, 1'b0);
    check("rst_oup_last", oup_last_o, 1'b0);
    check("rst_oup_addr", oup_addr_o, 32'h0);
    @(posedge clk); #1;
    rst_ni = 1'b1;

    // 1: single 4-beat burst
    xfers = 0; lasts = 0;
    run_task(32'h1000, 4, 0, 0);
    check("t1_model_bursts", model_len.size(), 1);
    check("t1_xfers", xfers, 4);
    check("t1_lasts", lasts, 1);
    check("t1_last_addr", last_addr, 32'h1000);

    // 2: page crossing splits 2 + 2
    xfers = 0; lasts = 0;
    run_task(32'h1FF0, 4, 0, 0);
    check("t2_model_len0", model_len[0], 2);
    check("t2_model_addr1", model_addr[1], 32'h2000);
    check("t2_lasts", lasts, 2);
    check("t2_last_addr", last_addr, 32'h2000);

    // 3: burst cap splits 256 + 44
    xfers = 0; lasts = 0;
    run_task(32'h0, 300, 0, 0);
    check("t3_model_len0", model_len[0], 256);
    check("t3_model_len1", model_len[1], 44);
    check("t3_model_addr1", model_addr[1], 32'h800);
    check("t3_xfers", xfers, 300);
    check("t3_last_addr", last_addr, 32'h800);

    // 4: stalls on both sides
    xfers = 0; lasts = 0;
    run_task(32'h3000, 16, 1, 0);
    check("t4_xfers", xfers, 16);
    check("t4_lasts", lasts, 1);

    // 5: zero-length task
    @(posedge clk); #1;
    task_addr  = 32'h300;
    task_len   = 0;
    task_valid = 1'b1;
    inp_valid  = 1'b1;
    oup_ready  = 1'b1;
    @(negedge clk);
    check("t5_task_ready", task_ready_o, 1'b1);
    @(posedge clk); #1;
    task_valid = 1'b0;
    check("t5_busy", busy_o, 1'b0);
    check("t5_task_ready_after", task_ready_o, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("t5_no_valid", oup_valid_o, 1'b0);
      check("t5_idle_busy", busy_o, 1'b0);
    end
    @(posedge clk); #1;
    inp_valid = 1'b0;

    // 6: reset after beat 3 of a len-8 task, then a clean len-2 task
    run_task(32'h100, 8, 0, 3);
    inp_valid = 1'b1;
    oup_ready = 1'b1;
    #1 rst_ni = 1'b0;
    #1;
    check("t6_task_ready", task_ready_o, 1'b1);
    check("t6_busy", busy_o, 1'b0);
    check("t6_oup_valid", oup_valid_o, 1'b0);
    check("t6_inp_ready", inp_ready_o, 1'b0);
    check("t6_oup_last", oup_last_o, 1'b0);
    check("t6_oup_addr", oup_addr_o, 32'h0);
    exp_q.delete();
    @(posedge clk); #1;
    inp_valid = 1'b0;
    rst_ni    = 1'b1;
    xfers = 0; lasts = 0;
    run_task(32'h40, 2, 0, 0);
    check("t6_xfers", xfers, 2);
    check("t6_last_addr", last_addr, 32'h40);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
